data_bus_responder: RTL and testbench

- Target-side of the core's data bus: services load/store requests issued by the core's bus controller (wd/rd, size, addr, data) against an internal word-organised data RAM.
- Supplies the ready/busy handshake that gates the core's program counter, and flags illegal accesses.
- Returns zero-extended read data; the core performs sign extension.
- Sits in the SoC next to the core top, one instance per data memory region.

---
 rtl/data_bus_responder.sv | 187 ++++++++++++++++++
 tb/tb_data_bus_responder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_bus_responder.sv
// Data-bus target for the core: services byte/half/word loads and stores against
// an internal word-organised RAM with a ready/busy handshake and an illegal-access fault pulse.
module data_bus_responder #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wd,
  input  logic        rd,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        ready,
  output logic        busy,
  output logic        fault
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [32:0] REGION_BYTES = 33'd1 << (ADDR_WIDTH + 2);
  localparam logic [3:0]  WAIT_INIT    = 4'(WAIT_STATES);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        armed_q, armed_d;
  logic        req_wd_q, req_wd_d;
  logic        req_rd_q, req_rd_d;
  logic [1:0]  req_size_q, req_size_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] req_data_q, req_data_d;
  logic [31:0] data_out_q, data_out_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic        fault_q, fault_d;

  logic [31:0] mem_q [2**ADDR_WIDTH];

  logic                  armed_now;
  logic                  accept;
  logic                  commit;
  logic [32:0]           offset;
  logic                  misaligned;
  logic                  illegal;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [31:0]           ram_word;
  logic [31:0]           merged;
  logic [31:0]           loaded;

  // A request the core is still holding must not re-execute; any change re-arms.
  assign armed_now = armed_q | ~(wd | rd)
                   | ({wd, rd, size, addr} != {req_wd_q, req_rd_q, req_size_q, req_addr_q});
  assign accept    = (state_q == S_IDLE) && (wd | rd) && armed_now;
  assign commit    = (state_q == S_ACCESS) && (cnt_q == 4'd0);

  // Borrow lands in bit 32, so addresses below the base compare as out of range.
  assign offset   = {1'b0, req_addr_q} - {1'b0, BASE_ADDR};
  assign word_idx = offset[ADDR_WIDTH+1:2];
  assign ram_word = mem_q[word_idx];

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves a latch behind.
    misaligned = 1'b0;
    unique case (req_size_q)
      SZ_HALF: misaligned = req_addr_q[0];
      SZ_WORD: misaligned = (req_addr_q[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
  end

  assign illegal = (req_wd_q & req_rd_q) || (req_size_q == 2'b11) || misaligned
                || (offset >= REGION_BYTES);

  always_comb begin
    merged = ram_word;
    loaded = 32'h0;
    unique case (req_size_q)
      SZ_BYTE: begin
        merged[{req_addr_q[1:0], 3'b000} +: 8] = req_data_q[7:0];
        loaded[7:0] = ram_word[{req_addr_q[1:0], 3'b000} +: 8];
      end
      SZ_HALF: begin
        merged[{req_addr_q[1], 4'b0000} +: 16] = req_data_q[15:0];
        loaded[15:0] = ram_word[{req_addr_q[1], 4'b0000} +: 16];
      end
      default: begin
        merged = req_data_q;
        loaded = ram_word;
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    armed_d    = armed_q;
    req_wd_d   = req_wd_q;
    req_rd_d   = req_rd_q;
    req_size_d = req_size_q;
    req_addr_d = req_addr_q;
    req_data_d = req_data_q;
    data_out_d = data_out_q;
    fault_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        armed_d = armed_now;
        if (accept) begin
          req_wd_d   = wd;
          req_rd_d   = rd;
          req_size_d = size;
          req_addr_d = addr;
          req_data_d = data_in;
          cnt_d      = WAIT_INIT;
          state_d    = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (commit) begin
          state_d = S_DONE;
          fault_d = illegal;
          if (illegal)       data_out_d = 32'h0;
          else if (req_rd_q) data_out_d = loaded;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        armed_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ready_d = (state_d == S_IDLE);
  assign busy_d  = (state_d == S_ACCESS);

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      armed_q    <= 1'b1;
      req_wd_q   <= 1'b0;
      req_rd_q   <= 1'b0;
      req_size_q <= 2'b00;
      req_addr_q <= 32'h0;
      req_data_q <= 32'h0;
      data_out_q <= 32'h0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      armed_q    <= armed_d;
      req_wd_q   <= req_wd_d;
      req_rd_q   <= req_rd_d;
      req_size_q <= req_size_d;
      req_addr_q <= req_addr_d;
      req_data_q <= req_data_d;
      data_out_q <= data_out_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      fault_q    <= fault_d;
    end
  end

  // NOTE: the RAM has no reset so it maps onto memory macros; reset forces IDLE, so no commit fires during it.
  always_ff @(posedge clk) begin
    if (commit && !illegal && req_wd_q) mem_q[word_idx] <= merged;
  end

  assign data_out = data_out_q;
  assign ready    = ready_q;
  assign busy     = busy_q;
  assign fault    = fault_q;

endmodule

// File: tb/tb_data_bus_responder.sv
// Scoreboard bench for data_bus_responder: three instances (WAIT_STATES 1, 0, 3)
// exercising merges, illegal accesses, held requests, reset abort and access spacing.
module tb_data_bus_responder;

  typedef struct {
    logic [31:0] data;
    logic        flt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wd_s   [3];
  logic        rd_s   [3];
  logic [1:0]  size_s [3];
  logic [31:0] addr_s [3];
  logic [31:0] din_s  [3];
  logic [31:0] dout_s [3];
  logic        ready_s[3];
  logic        busy_s [3];
  logic        fault_s[3];

  exp_t        sb[$];
  logic [31:0] last_rd[3];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    data_bus_responder #(
      .ADDR_WIDTH (10),
      .BASE_ADDR  (32'h0000_0000),
      .WAIT_STATES(g == 0 ? 1 : (g == 1 ? 0 : 3))
    ) u_dut (
      .clk     (clk),
      .rst     (rst),
      .wd      (wd_s[g]),
      .rd      (rd_s[g]),
      .size    (size_s[g]),
      .addr    (addr_s[g]),
      .data_in (din_s[g]),
      .data_out(dout_s[g]),
      .ready   (ready_s[g]),
      .busy    (busy_s[g]),
      .fault   (fault_s[g])
    );
  end

  function automatic int ws_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input int k, input logic w, input logic r, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] d);
    wd_s[k] = w; rd_s[k] = r; size_s[k] = sz; addr_s[k] = a; din_s[k] = d;
  endtask

  // Waits for the next accept, measures busy width, then checks the DONE cycle against the scoreboard.
  task automatic run_one(input int k, input string tag, output int t_acc, output int n_wait);
    int   w = 0;
    exp_t e;
    n_wait = 0;
    t_acc  = 0;
    do begin
      @(negedge clk);
      n_wait++;
    end while (!busy_s[k] && n_wait < 50);
    if (!busy_s[k]) begin
      chk({tag, "_accept_timeout"}, 32'd0, 32'd1);
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    t_acc = cyc;
    while (busy_s[k] && w < 50) begin
      w++;
      @(negedge clk);
    end
    chk({tag, "_busy_width"}, 32'(w), 32'(ws_of(k) + 1));
    chk({tag, "_done_ready"}, 32'(ready_s[k]), 32'd0);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_fault"}, 32'(fault_s[k]), 32'(e.flt));
    chk({tag, "_data"}, dout_s[k], e.data);
  endtask

  task automatic expect_push(input int k, input logic w, input logic r,
                             input logic [31:0] rd_exp, input logic flt);
    exp_t e;
    e.flt  = flt;
    e.data = flt ? 32'h0 : ((r && !w) ? rd_exp : last_rd[k]);
    last_rd[k] = e.data;
    sb.push_back(e);
  endtask

  task automatic do_access(input int k, input string tag, input logic w, input logic r,
                           input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] rd_exp, input logic flt);
    int t, n;
    expect_push(k, w, r, rd_exp, flt);
    @(negedge clk);
    drive(k, w, r, sz, a, d);
    run_one(k, tag, t, n);
    chk({tag, "_accept_latency"}, 32'(n), 32'd1);
    drive(k, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    @(negedge clk);
    chk({tag, "_ready_again"}, 32'(ready_s[k]), 32'd1);
  endtask

  task automatic back_to_back(input int k, input string tag, input logic [31:0] a1,
                              input logic [31:0] e1, input logic [31:0] a2, input logic [31:0] e2);
    int t1, t2, n;
    expect_push(k, 1'b0, 1'b1, e1, 1'b0);
    expect_push(k, 1'b0, 1'b1, e2, 1'b0);
    @(negedge clk);
    drive(k, 1'b0, 1'b1, 2'b10, a1, 32'h0);
    run_one(k, {tag, "_a"}, t1, n);
    addr_s[k] = a2;
    run_one(k, {tag, "_b"}, t2, n);
    chk({tag, "_spacing"}, 32'(t2 - t1), 32'(ws_of(k) + 3));
    drive(k, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, n, rises;
    for (int k = 0; k < 3; k++) begin
      drive(k, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
      last_rd[k] = 32'h0;
    end
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(ready_s[0]), 32'd0);
    chk("rst_busy", 32'(busy_s[0]), 32'd0);
    chk("rst_fault", 32'(fault_s[0]), 32'd0);
    chk("rst_data", dout_s[0], 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready_rise", 32'(ready_s[0]), 32'd1);

    do_access(0, "wr_word",   1, 0, 2'b10, 32'h10, 32'hDEAD_BEEF, 32'h0, 0);
    do_access(0, "rd_word",   0, 1, 2'b10, 32'h10, 32'h0, 32'hDEAD_BEEF, 0);
    do_access(0, "wr_byte",   1, 0, 2'b00, 32'h13, 32'h0000_00AA, 32'h0, 0);
    do_access(0, "wr_half",   1, 0, 2'b01, 32'h10, 32'h0000_1234, 32'h0, 0);
    do_access(0, "rd_merged", 0, 1, 2'b10, 32'h10, 32'h0, 32'hAAAD_1234, 0);
    do_access(0, "rd_byte",   0, 1, 2'b00, 32'h12, 32'h0, 32'h0000_00AD, 0);
    do_access(0, "rd_half_lo",0, 1, 2'b01, 32'h10, 32'h0, 32'h0000_1234, 0);

    do_access(0, "ill_half",  0, 1, 2'b01, 32'h11, 32'h0, 32'h0, 1);
    do_access(0, "ill_word",  1, 0, 2'b10, 32'h12, 32'hFFFF_FFFF, 32'h0, 1);
    do_access(0, "ill_size",  0, 1, 2'b11, 32'h10, 32'h0, 32'h0, 1);
    do_access(0, "ill_wdrd",  1, 1, 2'b10, 32'h10, 32'h5555_5555, 32'h0, 1);
    do_access(0, "ill_range", 1, 0, 2'b10, 32'h1000, 32'h7777_7777, 32'h0, 1);
    do_access(0, "rd_after_ill", 0, 1, 2'b10, 32'h10, 32'h0, 32'hAAAD_1234, 0);
    do_access(0, "rd_top_word",  0, 1, 2'b10, 32'hFFC, 32'h0, 32'h0, 0);
    do_access(0, "wr_14",     1, 0, 2'b10, 32'h14, 32'h5566_7788, 32'h0, 0);

    // Held request: one access only, then an address change is taken on the next edge.
    expect_push(0, 1'b0, 1'b1, 32'hAAAD_1234, 1'b0);
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 2'b10, 32'h10, 32'h0);
    run_one(0, "held1", t, n);
    rises = 0;
    repeat (8) begin
      @(negedge clk);
      if (busy_s[0]) rises++;
    end
    chk("held_single_access", 32'(rises), 32'd0);
    expect_push(0, 1'b0, 1'b1, 32'h5566_7788, 1'b0);
    addr_s[0] = 32'h14;
    run_one(0, "held2", t, n);
    chk("held2_same_cycle", 32'(n), 32'd1);
    drive(0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    @(negedge clk);

    // Reset during ACCESS aborts the write.
    do_access(0, "preload_20", 1, 0, 2'b10, 32'h20, 32'h0, 32'h0, 0);
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 2'b10, 32'h20, 32'h1111_1111);
    @(negedge clk);
    chk("abort_busy_before", 32'(busy_s[0]), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort_ready", 32'(ready_s[0]), 32'd0);
    chk("abort_busy", 32'(busy_s[0]), 32'd0);
    chk("abort_fault", 32'(fault_s[0]), 32'd0);
    chk("abort_data", dout_s[0], 32'h0);
    drive(0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    for (int k = 0; k < 3; k++) last_rd[k] = 32'h0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ready_rise", 32'(ready_s[0]), 32'd1);
    do_access(0, "rd_20_after_abort", 0, 1, 2'b10, 32'h20, 32'h0, 32'h0, 0);

    // WAIT_STATES=0 and WAIT_STATES=3 timing.
    do_access(1, "ws0_wr40", 1, 0, 2'b10, 32'h40, 32'hCAFE_F00D, 32'h0, 0);
    do_access(1, "ws0_wr44", 1, 0, 2'b10, 32'h44, 32'h0BAD_C0DE, 32'h0, 0);
    back_to_back(1, "ws0_b2b", 32'h40, 32'hCAFE_F00D, 32'h44, 32'h0BAD_C0DE);
    do_access(2, "ws3_wr80", 1, 0, 2'b10, 32'h80, 32'h1357_9BDF, 32'h0, 0);
    do_access(2, "ws3_wr84", 1, 0, 2'b10, 32'h84, 32'h2468_ACE0, 32'h0, 0);
    back_to_back(2, "ws3_b2b", 32'h80, 32'h1357_9BDF, 32'h84, 32'h2468_ACE0);
    do_access(2, "ws3_rd_byte", 0, 1, 2'b00, 32'h87, 32'h0, 32'h0000_0024, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
